irq_priority_ctrl: RTL and testbench

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

---
 rtl/irq_priority_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_irq_priority_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl
//
// Purpose:
//   Interrupt priority controller. It collects per-source pending flags, picks
//   one candidate, raises a registered request with the handler vector, and
//   tracks the request/service handshake with the CPU (ack / reti). While a
//   handler runs, no new request is raised (no nesting).
//
// Build option:
//   IRQ_ROUND_ROBIN_EN - when defined, arbitration is round-robin. The search
//                        starts at a pointer that moves to (k+1) mod NUM_SRC
//                        whenever source k is acknowledged. When undefined, the
//                        lowest-index candidate always wins and no pointer
//                        exists.
//
// Parameters:
//   NUM_SRC        number of interrupt sources (1..16)
//   I_ADDR_WIDTH   width of the handler vector
//   VECTOR_BASE    vector of source 0
//   VECTOR_STRIDE  vector spacing between consecutive sources
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous active-low reset
//   src_flag    in   per-source pending flags (bit i = source i)
//   src_mask    in   per-source enables (1 = unmasked)
//   global_en   in   global interrupt enable (SREG I bit)
//   ack         in   one-cycle pulse, CPU takes the request
//   reti        in   one-cycle pulse, handler returns
//   irq         out  registered interrupt request
//   vector      out  registered handler address
//   flag_clr    out  one-hot, one-cycle pulse clearing the acknowledged flag
//   in_service  out  high while a handler executes
//   active_id   out  index of the selected or serviced source
// -----------------------------------------------------------------------------
module irq_priority_ctrl #(
   parameter int NUM_SRC       = 8,
   parameter int I_ADDR_WIDTH  = 10,
   parameter int VECTOR_BASE   = 1,
   parameter int VECTOR_STRIDE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_SRC-1:0]      src_flag,
   input  logic [NUM_SRC-1:0]      src_mask,
   input  logic                    global_en,
   input  logic                    ack,
   input  logic                    reti,
   output logic                    irq,
   output logic [I_ADDR_WIDTH-1:0] vector,
   output logic [NUM_SRC-1:0]      flag_clr,
   output logic                    in_service,
   output logic [3:0]              active_id
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQUEST = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   // ------------------------------------------------------------------------
   // Registers and their next values
   // ------------------------------------------------------------------------
   logic [1:0]              state_reg,      state_next;
   logic                    irq_reg,        irq_next;
   logic [I_ADDR_WIDTH-1:0] vector_reg,     vector_next;
   logic [NUM_SRC-1:0]      flag_clr_reg,   flag_clr_next;
   logic                    in_service_reg, in_service_next;
   logic [3:0]              active_id_reg,  active_id_next;

   // ------------------------------------------------------------------------
   // Candidate set, vector table, one-hot of the current source
   // ------------------------------------------------------------------------
   logic [NUM_SRC-1:0]      cand;
   logic                    any_cand;
   logic [I_ADDR_WIDTH-1:0] vec_table [NUM_SRC];
   logic [NUM_SRC-1:0]      active_onehot;

   assign cand     = src_flag & src_mask & {NUM_SRC{global_en}};
   assign any_cand = |cand;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         // Vectors are elaboration-time constants; the cast truncates to the
         // vector width, which gives the required wrap-around.
         localparam int VEC_INT = VECTOR_BASE + gi * VECTOR_STRIDE;
         assign vec_table[gi]     = I_ADDR_WIDTH'(VEC_INT);
         // flag_clr is taken from the registered source id, so a winner change
         // on the ack edge cannot redirect the clear to a different source.
         assign active_onehot[gi] = (active_id_reg == 4'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   logic [3:0] win_idx;

`ifdef IRQ_ROUND_ROBIN_EN
   logic [3:0]         ptr_reg, ptr_next;
   logic [NUM_SRC-1:0] cand_rot;
   logic [3:0]         win_off;

   // Rotate the candidate set so that bit 0 is the source at the pointer;
   // the lowest set bit of the rotated vector is then the round-robin winner.
   always_comb begin
      cand_rot = cand;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (ptr_reg == 4'(j)) begin
            cand_rot = NUM_SRC'({cand, cand} >> j);
         end
      end
   end

   always_comb begin
      win_off = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (cand_rot[i]) begin
            win_off = 4'(i);
         end
      end
   end

   // Map the offset back to a source index, wrapping at NUM_SRC.
   always_comb begin
      if (({1'b0, ptr_reg} + {1'b0, win_off}) >= 5'(NUM_SRC)) begin
         win_idx = ptr_reg + win_off - 4'(NUM_SRC);
      end else begin
         win_idx = ptr_reg + win_off;
      end
   end
`else
   // Fixed priority: scan downward so the lowest-index candidate is the last
   // assignment and therefore wins.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_idx = 4'(i);
         end
      end
   end
`endif

   // Vector lookup for the current winner.
   logic [I_ADDR_WIDTH-1:0] win_vec;

   always_comb begin
      win_vec = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (win_idx == 4'(i)) begin
            win_vec = vec_table[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      irq_next        = irq_reg;
      vector_next     = vector_reg;
      active_id_next  = active_id_reg;
      in_service_next = in_service_reg;
      flag_clr_next   = '0;      // pulse lasts exactly one cycle

      case (state_reg)
         ST_IDLE: begin
            if (any_cand) begin
               state_next     = ST_REQUEST;
               irq_next       = 1'b1;
               vector_next    = win_vec;
               active_id_next = win_idx;
            end else begin
               // No candidate: drop the request, vector and id hold.
               irq_next = 1'b0;
            end
         end

         ST_REQUEST: begin
            if (ack) begin
               // The CPU took the request that was on the outputs before this
               // edge, so everything is frozen from the registered values.
               state_next      = ST_SERVICE;
               irq_next        = 1'b0;
               in_service_next = 1'b1;
               flag_clr_next   = active_onehot;
            end else if (any_cand) begin
               // Re-arbitrate every cycle so a higher-priority arrival
               // replaces the pending one before the CPU takes it.
               irq_next       = 1'b1;
               vector_next    = win_vec;
               active_id_next = win_idx;
            end else begin
               // Request withdrawn (global_en fell or flag cleared).
               state_next = ST_IDLE;
               irq_next   = 1'b0;
            end
         end

         ST_SERVICE: begin
            // No nesting: candidates stay pending until the handler returns.
            irq_next = 1'b0;
            if (reti) begin
               state_next      = ST_IDLE;
               in_service_next = 1'b0;
            end
         end

         default: begin
            state_next      = ST_IDLE;
            irq_next        = 1'b0;
            in_service_next = 1'b0;
         end
      endcase
   end

`ifdef IRQ_ROUND_ROBIN_EN
   // The pointer moves past the acknowledged source so it becomes the
   // lowest priority for the next arbitration.
   always_comb begin
      ptr_next = ptr_reg;
      if ((state_reg == ST_REQUEST) && ack) begin
         if (active_id_reg == 4'(NUM_SRC - 1)) begin
            ptr_next = '0;
         end else begin
            ptr_next = active_id_reg + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         irq_reg        <= 1'b0;
         vector_reg     <= '0;
         flag_clr_reg   <= '0;
         in_service_reg <= 1'b0;
         active_id_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         irq_reg        <= irq_next;
         vector_reg     <= vector_next;
         flag_clr_reg   <= flag_clr_next;
         in_service_reg <= in_service_next;
         active_id_reg  <= active_id_next;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign irq        = irq_reg;
   assign vector     = vector_reg;
   assign flag_clr   = flag_clr_reg;
   assign in_service = in_service_reg;
   assign active_id  = active_id_reg;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_priority_ctrl
//
// Scoreboard bench for irq_priority_ctrl with default parameters
// (8 sources, 10-bit vectors, base 1, stride 1). Each transaction pushes the
// expected output snapshot before the clock edge and pops/compares it after.
// Define IRQ_ROUND_ROBIN_EN for the round-robin sequence.
// -----------------------------------------------------------------------------
module tb_irq_priority_ctrl;

   localparam int NUM_SRC = 8;
   localparam int AW      = 10;
   localparam int SNAP_W  = 1 + AW + NUM_SRC + 1 + 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [NUM_SRC-1:0] src_flag;
   logic [NUM_SRC-1:0] src_mask;
   logic               global_en;
   logic               ack;
   logic               reti;
   logic               irq;
   logic [AW-1:0]      vector;
   logic [NUM_SRC-1:0] flag_clr;
   logic               in_service;
   logic [3:0]         active_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string             tag;
      logic [SNAP_W-1:0] exp;
   } exp_t;

   exp_t sb_q[$];

   irq_priority_ctrl #(
      .NUM_SRC       (NUM_SRC),
      .I_ADDR_WIDTH  (AW),
      .VECTOR_BASE   (1),
      .VECTOR_STRIDE (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .src_flag   (src_flag),
      .src_mask   (src_mask),
      .global_en  (global_en),
      .ack        (ack),
      .reti       (reti),
      .irq        (irq),
      .vector     (vector),
      .flag_clr   (flag_clr),
      .in_service (in_service),
      .active_id  (active_id)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports a mismatch.
   task automatic check_eq(input string tag, input logic [SNAP_W-1:0] act,
                           input logic [SNAP_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got irq/vec/clr/isv/id=%0d/%0d/%h/%0d/%0d expected %0d/%0d/%h/%0d/%0d",
                  tag, act[SNAP_W-1], act[SNAP_W-2 -: AW], act[NUM_SRC+4 -: NUM_SRC],
                  act[4], act[3:0], exp[SNAP_W-1], exp[SNAP_W-2 -: AW],
                  exp[NUM_SRC+4 -: NUM_SRC], exp[4], exp[3:0]);
      end
   endtask

   task automatic expect_out(input string tag, input logic e_irq, input logic [AW-1:0] e_vec,
                             input logic [NUM_SRC-1:0] e_clr, input logic e_isv,
                             input logic [3:0] e_id);
      exp_t e;
      e.tag = tag;
      e.exp = {e_irq, e_vec, e_clr, e_isv, e_id};
      sb_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb_q.pop_front();
         $display("txn %-12s irq=%0d vector=%0d flag_clr=%h in_service=%0d active_id=%0d",
                  e.tag, irq, vector, flag_clr, in_service, active_id);
         check_eq(e.tag, {irq, vector, flag_clr, in_service, active_id}, e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clocked transaction: inputs already driven, expectation queued,
   // one edge, then the comparison.
   task automatic cycle(input string tag, input logic e_irq, input logic [AW-1:0] e_vec,
                        input logic [NUM_SRC-1:0] e_clr, input logic e_isv,
                        input logic [3:0] e_id);
      expect_out(tag, e_irq, e_vec, e_clr, e_isv, e_id);
      step();
      compare_out();
   endtask

   // Called while the DUT is in SERVICE: reset must clear everything without
   // a clock edge, never emit flag_clr, and stray ack/reti must do nothing.
   task automatic reset_mid_service();
      #2;
      reset = 1'b0;
      #1;
      expect_out("async_rst", 1'b0, '0, '0, 1'b0, 4'd0);
      compare_out();
      ack = 1'b1;
      cycle("rst_held", 1'b0, '0, '0, 1'b0, 4'd0);
      ack = 1'b0;
      cycle("rst_held2", 1'b0, '0, '0, 1'b0, 4'd0);
      reset     = 1'b1;
      global_en = 1'b0;
      ack       = 1'b1;
      cycle("stray_ack", 1'b0, '0, '0, 1'b0, 4'd0);
      ack  = 1'b0;
      reti = 1'b1;
      cycle("stray_reti", 1'b0, '0, '0, 1'b0, 4'd0);
      reti = 1'b0;
      cycle("idle_quiet", 1'b0, '0, '0, 1'b0, 4'd0);
   endtask

   initial begin
      reset     = 1'b1;
      src_flag  = '0;
      src_mask  = '0;
      global_en = 1'b0;
      ack       = 1'b0;
      reti      = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      expect_out("reset", 1'b0, '0, '0, 1'b0, 4'd0);
      compare_out();
      step();
      step();
      reset = 1'b1;

`ifdef IRQ_ROUND_ROBIN_EN
      // Both sources stay pending; the pointer alternates the winner.
      global_en = 1'b1;
      src_mask  = 8'hFF;
      src_flag  = 8'h03;
      for (int k = 0; k < 4; k++) begin
         cycle("rr_req", 1'b1, AW'(k % 2 + 1), '0, 1'b0, 4'(k % 2));
         ack = 1'b1;
         cycle("rr_ack", 1'b0, AW'(k % 2 + 1), NUM_SRC'(1 << (k % 2)), 1'b1, 4'(k % 2));
         ack  = 1'b0;
         reti = 1'b1;
         cycle("rr_reti", 1'b0, AW'(k % 2 + 1), '0, 1'b0, 4'(k % 2));
         reti = 1'b0;
      end
      cycle("rr_req5", 1'b1, 10'd1, '0, 1'b0, 4'd0);
      ack = 1'b1;
      cycle("rr_ack5", 1'b0, 10'd1, 8'h01, 1'b1, 4'd0);
      ack = 1'b0;
      reset_mid_service();
`else
      // Single source: request, ack, service, return.
      global_en = 1'b1;
      src_mask  = 8'h01;
      src_flag  = 8'h01;
      cycle("s0_req", 1'b1, 10'd1, '0, 1'b0, 4'd0);
      ack = 1'b1;
      cycle("s0_ack", 1'b0, 10'd1, 8'h01, 1'b1, 4'd0);
      ack      = 1'b0;
      src_flag = 8'h00;
      cycle("s0_svc", 1'b0, 10'd1, '0, 1'b1, 4'd0);
      reti = 1'b1;
      cycle("s0_reti", 1'b0, 10'd1, '0, 1'b0, 4'd0);
      reti = 1'b0;
      cycle("idle_hold", 1'b0, 10'd1, '0, 1'b0, 4'd0);

      // Two sources: lowest index wins; the other waits out the handler.
      src_mask = 8'hFF;
      src_flag = 8'h0C;
      cycle("s2_req", 1'b1, 10'd3, '0, 1'b0, 4'd2);
      ack = 1'b1;
      cycle("s2_ack", 1'b0, 10'd3, 8'h04, 1'b1, 4'd2);
      ack      = 1'b0;
      src_flag = 8'h08;
      cycle("no_nest", 1'b0, 10'd3, '0, 1'b1, 4'd2);
      reti = 1'b1;
      cycle("s2_reti", 1'b0, 10'd3, '0, 1'b0, 4'd2);
      reti = 1'b0;
      cycle("s3_req", 1'b1, 10'd4, '0, 1'b0, 4'd3);

      // Withdrawal: global_en drops while requesting.
      global_en = 1'b0;
      cycle("withdraw", 1'b0, 10'd4, '0, 1'b0, 4'd3);
      cycle("wd_idle", 1'b0, 10'd4, '0, 1'b0, 4'd3);

      // Preemption while requesting.
      global_en = 1'b1;
      cycle("s3_again", 1'b1, 10'd4, '0, 1'b0, 4'd3);
      src_flag = 8'h0A;
      cycle("preempt", 1'b1, 10'd2, '0, 1'b0, 4'd1);

      // Ack coincides with a new winner: the registered one is serviced.
      src_flag = 8'h0B;
      ack      = 1'b1;
      cycle("ack_race", 1'b0, 10'd2, 8'h02, 1'b1, 4'd1);
      src_flag = 8'h09;
      cycle("svc_hold", 1'b0, 10'd2, '0, 1'b1, 4'd1);
      cycle("svc_ack_ig", 1'b0, 10'd2, '0, 1'b1, 4'd1);
      ack  = 1'b0;
      reti = 1'b1;
      cycle("race_reti", 1'b0, 10'd2, '0, 1'b0, 4'd1);
      reti = 1'b0;
      cycle("s0_win", 1'b1, 10'd1, '0, 1'b0, 4'd0);

      // Masking source 0 hands the request to source 3.
      src_mask = 8'hFE;
      cycle("mask_s0", 1'b1, 10'd4, '0, 1'b0, 4'd3);
      ack = 1'b1;
      cycle("s3_ack", 1'b0, 10'd4, 8'h08, 1'b1, 4'd3);
      ack = 1'b0;
      cycle("s3_svc", 1'b0, 10'd4, '0, 1'b1, 4'd3);
      reset_mid_service();
`endif

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_left: got %0d entries expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Catch any flag_clr pulse while reset is asserted.
   always @(negedge clk) begin
      if (reset === 1'b0 && flag_clr !== '0) begin
         checks++;
         errors++;
         $display("FAIL clr_in_reset: got %h expected 00", flag_clr);
      end
   end

endmodule
